onewire_slot_engine: RTL and testbench

Parametrised 1-Wire master slot generator that supersedes the reset-only timer. It performs one of four bus operations per command: reset/presence, write-0, write-1, or read-bit. Timing scales with the CLK_MHZ parameter. It sits between the byte-level 1-Wire controller (command issuer) and the open-drain pad logic, which turns drive_low into a bus pull-down.

---
 rtl/onewire_pkg.sv | 87 ++++++++
 rtl/onewire_sync.sv | 29 ++
 rtl/onewire_slot_engine.sv | 171 +++++++++++++++++
 tb/tb_onewire_slot_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// 1-Wire slot engine package: command/state enums, µs timing tables and cycle-count helper.
// Overdrive tables are elaborated only when ONEWIRE_OVERDRIVE_EN is defined.
package onewire_pkg;

  typedef enum logic [1:0] {
    OW_RESET  = 2'd0,
    OW_WRITE0 = 2'd1,
    OW_WRITE1 = 2'd2,
    OW_READ   = 2'd3
  } ow_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOW     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RECOVER = 2'd3
  } ow_state_t;

  typedef struct packed {
    int low;
    int smp;
    int slot;
    int rec;
  } ow_timing_t;

  localparam int STD_RST_LOW_US  = 480;
  localparam int STD_RST_SMP_US  = 550;
  localparam int STD_RST_SLOT_US = 960;
  localparam int STD_W0_LOW_US   = 60;
  localparam int STD_W1_LOW_US   = 6;
  localparam int STD_RD_LOW_US   = 6;
  localparam int STD_RD_SMP_US   = 15;
  localparam int STD_BIT_SLOT_US = 70;
  localparam int STD_REC_US      = 10;

`ifdef ONEWIRE_OVERDRIVE_EN
  localparam int OD_RST_LOW_US  = 70;
  localparam int OD_RST_SMP_US  = 78;
  localparam int OD_RST_SLOT_US = 118;
  localparam int OD_W0_LOW_US   = 8;
  localparam int OD_W1_LOW_US   = 1;
  localparam int OD_RD_LOW_US   = 1;
  localparam int OD_RD_SMP_US   = 2;
  localparam int OD_BIT_SLOT_US = 10;
  localparam int OD_REC_US      = 2;
`endif

  // Write slots carry smp=0; the engine never samples during them.
  function automatic ow_timing_t ow_us_std(input ow_cmd_t cmd);
    ow_timing_t us;
    case (cmd)
      OW_RESET:  us = '{STD_RST_LOW_US, STD_RST_SMP_US, STD_RST_SLOT_US, STD_REC_US};
      OW_WRITE0: us = '{STD_W0_LOW_US, 0, STD_BIT_SLOT_US, STD_REC_US};
      OW_WRITE1: us = '{STD_W1_LOW_US, 0, STD_BIT_SLOT_US, STD_REC_US};
      default:   us = '{STD_RD_LOW_US, STD_RD_SMP_US, STD_BIT_SLOT_US, STD_REC_US};
    endcase
    return us;
  endfunction

`ifdef ONEWIRE_OVERDRIVE_EN
  function automatic ow_timing_t ow_us_od(input ow_cmd_t cmd);
    ow_timing_t us;
    case (cmd)
      OW_RESET:  us = '{OD_RST_LOW_US, OD_RST_SMP_US, OD_RST_SLOT_US, OD_REC_US};
      OW_WRITE0: us = '{OD_W0_LOW_US, 0, OD_BIT_SLOT_US, OD_REC_US};
      OW_WRITE1: us = '{OD_W1_LOW_US, 0, OD_BIT_SLOT_US, OD_REC_US};
      default:   us = '{OD_RD_LOW_US, OD_RD_SMP_US, OD_BIT_SLOT_US, OD_REC_US};
    endcase
    return us;
  endfunction
`endif

  function automatic ow_timing_t ow_timing(input ow_cmd_t cmd, input logic od, input int clk_mhz);
    ow_timing_t us;
    ow_timing_t cyc;
    us = ow_us_std(cmd);
`ifdef ONEWIRE_OVERDRIVE_EN
    if (od) us = ow_us_od(cmd);
`else
    // Without overdrive support, od selects the standard table as well.
    if (od) us = ow_us_std(cmd);
`endif
    cyc = '{us.low * clk_mhz, us.smp * clk_mhz, us.slot * clk_mhz, us.rec * clk_mhz};
    return cyc;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the raw 1-Wire line; resets to 1, the idle bus level.
module onewire_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/onewire_slot_engine.sv
// 1-Wire master slot generator: reset/presence, write-0, write-1 and read-bit slots.
// Defining ONEWIRE_OVERDRIVE_EN adds the od_mode input and overdrive timing.
//
// state      | meaning
// ST_IDLE    | waiting for start; bus released
// ST_LOW     | master pulls the bus low
// ST_RELEASE | bus released; RESET/READ sample point lies here
// ST_RECOVER | inter-slot recovery; done on the last cycle
module onewire_slot_engine
  import onewire_pkg::*;
#(
  parameter int CLK_MHZ = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic       bus_in,
`ifdef ONEWIRE_OVERDRIVE_EN
  input  logic       od_mode,
`endif
  output logic       busy,
  output logic       drive_low,
  output logic       sample,
  output logic       presence,
  output logic       rx_bit,
  output logic       done
);

  localparam int CW = $clog2((STD_RST_SLOT_US + STD_REC_US) * CLK_MHZ + 1);

  // Terminal-count compare values, all resolved at elaboration.
  typedef struct packed {
    logic [CW-1:0] low_end;
    logic [CW-1:0] smp;
    logic [CW-1:0] slot_end;
    logic [CW-1:0] last;
  } tc_t;

  function automatic tc_t to_tc(input ow_timing_t t);
    tc_t tc;
    tc.low_end  = CW'(t.low - 1);
    tc.smp      = CW'(t.smp);
    tc.slot_end = CW'(t.slot - 1);
    tc.last     = CW'(t.slot + t.rec - 1);
    return tc;
  endfunction

  localparam tc_t TC_RST = to_tc(ow_timing(OW_RESET,  1'b0, CLK_MHZ));
  localparam tc_t TC_W0  = to_tc(ow_timing(OW_WRITE0, 1'b0, CLK_MHZ));
  localparam tc_t TC_W1  = to_tc(ow_timing(OW_WRITE1, 1'b0, CLK_MHZ));
  localparam tc_t TC_RD  = to_tc(ow_timing(OW_READ,   1'b0, CLK_MHZ));
`ifdef ONEWIRE_OVERDRIVE_EN
  localparam tc_t TC_OD_RST = to_tc(ow_timing(OW_RESET,  1'b1, CLK_MHZ));
  localparam tc_t TC_OD_W0  = to_tc(ow_timing(OW_WRITE0, 1'b1, CLK_MHZ));
  localparam tc_t TC_OD_W1  = to_tc(ow_timing(OW_WRITE1, 1'b1, CLK_MHZ));
  localparam tc_t TC_OD_RD  = to_tc(ow_timing(OW_READ,   1'b1, CLK_MHZ));
`endif

  ow_state_t     state_q, state_d;
  ow_cmd_t       cmd_q, cmd_d;
  logic [CW-1:0] t_q, t_d;
  logic          presence_q, presence_d;
  logic          rx_bit_q, rx_bit_d;
  logic          bus_sync;
  logic          has_smp;
  tc_t           tc;
`ifdef ONEWIRE_OVERDRIVE_EN
  logic          od_q, od_d;
`endif

  onewire_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_in),
    .q     (bus_sync)
  );

  always_comb begin
    case (cmd_q)
      OW_RESET:  tc = TC_RST;
      OW_WRITE0: tc = TC_W0;
      OW_WRITE1: tc = TC_W1;
      default:   tc = TC_RD;
    endcase
`ifdef ONEWIRE_OVERDRIVE_EN
    if (od_q) begin
      case (cmd_q)
        OW_RESET:  tc = TC_OD_RST;
        OW_WRITE0: tc = TC_OD_W0;
        OW_WRITE1: tc = TC_OD_W1;
        default:   tc = TC_OD_RD;
      endcase
    end
`endif
  end

  assign has_smp = (cmd_q == OW_RESET) || (cmd_q == OW_READ);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    t_d        = t_q + CW'(1);
    presence_d = presence_q;
    rx_bit_d   = rx_bit_q;
    drive_low  = 1'b0;
    sample     = 1'b0;
    done       = 1'b0;
`ifdef ONEWIRE_OVERDRIVE_EN
    od_d       = od_q;
`endif
    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (start) begin
          cmd_d   = ow_cmd_t'(cmd);
`ifdef ONEWIRE_OVERDRIVE_EN
          od_d    = od_mode;
`endif
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        drive_low = 1'b1;
        if (t_q == tc.low_end) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (has_smp && (t_q == tc.smp)) begin
          sample = 1'b1;
          if (cmd_q == OW_RESET) presence_d = ~bus_sync;
          else                   rx_bit_d   = bus_sync;
        end
        if (t_q == tc.slot_end) state_d = ST_RECOVER;
      end
      default: begin
        if (t_q == tc.last) begin
          done    = 1'b1;
          t_d     = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= OW_RESET;
      t_q        <= '0;
      presence_q <= 1'b0;
      rx_bit_q   <= 1'b0;
`ifdef ONEWIRE_OVERDRIVE_EN
      od_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      t_q        <= t_d;
      presence_q <= presence_d;
      rx_bit_q   <= rx_bit_d;
`ifdef ONEWIRE_OVERDRIVE_EN
      od_q       <= od_d;
`endif
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign presence = presence_q;
  assign rx_bit   = rx_bit_q;

endmodule

// File: tb/tb_onewire_slot_engine.sv
// Self-checking bench for onewire_slot_engine (CLK_MHZ=27) with an event scoreboard.
module tb_onewire_slot_engine;

  localparam int MHZ = 27;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       bus_in;
`ifdef ONEWIRE_OVERDRIVE_EN
  logic       od_mode = 1'b0;
`endif
  logic       busy, drive_low, sample, presence, rx_bit, done;

  int checks = 0;
  int failures = 0;
  int cyc_abs = 0;
  int t0 = 0;

  // kind: 0 drive_low rise, 1 drive_low fall, 2 sample pulse, 3 done pulse
  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  logic exp_presence = 1'b0;
  logic exp_rx = 1'b0;

  logic dev_en = 1'b0;
  int   dev_lo = 0;
  int   dev_hi = 0;
  logic dev_pull;
  logic prev_dl = 1'b0;

  onewire_slot_engine #(.CLK_MHZ(MHZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .bus_in    (bus_in),
`ifdef ONEWIRE_OVERDRIVE_EN
    .od_mode   (od_mode),
`endif
    .busy      (busy),
    .drive_low (drive_low),
    .sample    (sample),
    .presence  (presence),
    .rx_bit    (rx_bit),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // Open-drain wire: low when the master drives or the modelled device pulls.
  always_comb dev_pull = dev_en && ((cyc_abs - t0) >= dev_lo) && ((cyc_abs - t0) < dev_hi);
  assign bus_in = !(drive_low || dev_pull);

  always @(negedge clk) begin : scoreboard
    logic [3:0] ev;
    ev_t        e;
    int         rel;
    rel = cyc_abs - t0;
    ev = {done === 1'b1, sample === 1'b1, prev_dl && (drive_low === 1'b0), (drive_low === 1'b1) && !prev_dl};
    prev_dl <= (drive_low === 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_event got kind=%0d cycle=%0d, expected no event", k, rel);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.cyc != rel) begin
            failures++;
            $display("FAIL sb_event got kind=%0d cycle=%0d, expected kind=%0d cycle=%0d", k, rel, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic expect_op(input int low, input int smp, input int slot, input int rec, input int base);
    exp_q.push_back(ev_t'{0, base + 1});
    exp_q.push_back(ev_t'{1, base + low * MHZ + 1});
    if (smp > 0) exp_q.push_back(ev_t'{2, base + smp * MHZ + 1});
    exp_q.push_back(ev_t'{3, base + (slot + rec) * MHZ});
  endtask

  task automatic issue(input logic [1:0] c);
    @(negedge clk);
    cmd = c;
    start = 1'b1;
    t0 = cyc_abs;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output int seen);
    seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, drive_low, sample, presence, rx_bit, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=000000", {busy, drive_low, sample, presence, rx_bit, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_presence(input logic dev_answers, input string name);
    int seen;
    dev_en = dev_answers;
    dev_lo = 500 * MHZ;
    dev_hi = 800 * MHZ;
    expect_op(480, 550, 960, 10, 0);
    issue(2'd0);
    wait_done(1, 30000, seen);
    exp_presence = dev_answers;
    checks++;
    if (seen != 1) begin failures++; $display("FAIL %s done_count got=%0d expected=1", name, seen); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b expected=0", name, busy); end
    checks++;
    if (presence !== exp_presence) begin failures++; $display("FAIL %s presence got=%b expected=%b", name, presence, exp_presence); end
    checks++;
    if (rx_bit !== exp_rx) begin failures++; $display("FAIL %s rx_kept got=%b expected=%b", name, rx_bit, exp_rx); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s missing_events got=%0d expected=0", name, exp_q.size()); end
    dev_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_read(input logic bus_level);
    int seen;
    dev_en = !bus_level;
    dev_lo = 7 * MHZ;
    dev_hi = 30 * MHZ;
    expect_op(6, 15, 70, 10, 0);
    issue(2'd3);
    wait_done(1, 3000, seen);
    exp_rx = bus_level;
    checks++;
    if (seen != 1) begin failures++; $display("FAIL read done_count got=%0d expected=1", seen); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL read busy_after got=%b expected=0", busy); end
    checks++;
    if (rx_bit !== exp_rx) begin failures++; $display("FAIL read rx_bit got=%b expected=%b", rx_bit, exp_rx); end
    checks++;
    if (presence !== exp_presence) begin failures++; $display("FAIL read presence_kept got=%b expected=%b", presence, exp_presence); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL read missing_events got=%0d expected=0", exp_q.size()); end
    dev_en = 1'b0;
    exp_q.delete();
  endtask

  // Device pulls low around the read sample point; writes must not capture it.
  task automatic test_write(input logic [1:0] c, input int low_us);
    int seen;
    dev_en = 1'b1;
    dev_lo = 7 * MHZ;
    dev_hi = 30 * MHZ;
    expect_op(low_us, 0, 70, 10, 0);
    issue(c);
    wait_done(1, 3000, seen);
    checks++;
    if (seen != 1) begin failures++; $display("FAIL write%0d done_count got=%0d expected=1", c - 2'd1, seen); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write busy_after got=%b expected=0", busy); end
    checks++;
    if ({presence, rx_bit} !== {exp_presence, exp_rx}) begin
      failures++;
      $display("FAIL write flags_kept got=%b expected=%b", {presence, rx_bit}, {exp_presence, exp_rx});
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL write missing_events got=%0d expected=0", exp_q.size()); end
    dev_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_restart_ignored();
    int seen;
    expect_op(60, 0, 70, 10, 0);
    issue(2'd1);
    repeat (99) @(negedge clk);
    cmd = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (899) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, 2500, seen);
    checks++;
    if (seen != 1) begin failures++; $display("FAIL restart done_count got=%0d expected=1", seen); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL restart busy_after got=%b expected=0", busy); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL restart missing_events got=%0d expected=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int seen;
    expect_op(6, 0, 70, 10, 0);
    expect_op(6, 0, 70, 10, 80 * MHZ + 1);
    @(negedge clk);
    cmd = 2'd2;
    start = 1'b1;
    t0 = cyc_abs;
    repeat (80 * MHZ + 2) @(negedge clk);
    start = 1'b0;
    wait_done(1, 3000, seen);
    checks++;
    if (seen != 1) begin failures++; $display("FAIL b2b second_done got=%0d expected=1", seen); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b busy_after got=%b expected=0", busy); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b missing_events got=%0d expected=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int seen;
    exp_q.push_back(ev_t'{0, 1});
    exp_q.push_back(ev_t'{1, 500});
    issue(2'd0);
    repeat (499) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({drive_low, busy} !== 2'b00) begin failures++; $display("FAIL abort release got=%b expected=00", {drive_low, busy}); end
    repeat (4) @(negedge clk);
    exp_presence = 1'b0;
    exp_rx = 1'b0;
    checks++;
    if ({presence, rx_bit, done} !== 3'b000) begin failures++; $display("FAIL abort cleared got=%b expected=000", {presence, rx_bit, done}); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL abort missing_events got=%0d expected=0", exp_q.size()); end
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    expect_op(6, 0, 70, 10, 0);
    issue(2'd2);
    wait_done(1, 3000, seen);
    checks++;
    if (seen != 1) begin failures++; $display("FAIL abort post_op_done got=%0d expected=1", seen); end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL abort post_op_events got=%0d expected=0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef ONEWIRE_OVERDRIVE_EN
  task automatic test_overdrive();
    int seen;
    od_mode = 1'b1;
    expect_op(8, 0, 10, 2, 0);
    issue(2'd1);
    od_mode = 1'b0;
    wait_done(1, 1000, seen);
    checks++;
    if (seen != 1) begin failures++; $display("FAIL od_write0 done_count got=%0d expected=1", seen); end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL od_write0 missing_events got=%0d expected=0", exp_q.size()); end
    exp_q.delete();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_reset_presence(1'b1, "reset_presence");
    test_read(1'b1);
    test_write(2'd2, 6);
    test_write(2'd1, 60);
    test_restart_ignored();
    test_back_to_back();
    test_reset_presence(1'b0, "reset_no_presence");
    test_abort();
    test_read(1'b1);
    test_read(1'b0);
`ifdef ONEWIRE_OVERDRIVE_EN
    test_overdrive();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
